ram_access_ctrl: RTL and testbench
==================================

Name: ram_access_ctrl

Overview:
Data-memory access controller directly downstream of the core's RAM port. Consumes the core's single-cycle load/store requests and turns them into a req/ready handshake toward a wait-stated data SRAM/bus. Returns load data to the core, and raises a stall request so CoreCtrl freezes the pipeline until each access completes. Adds byte-enable generation, alignment checking and a bus-timeout watchdog.

Parameters:
TIMEOUT_CYCLES, 255, number of cycles mem_req may wait for mem_ready before the access is aborted (1..65535)
ERR_RDATA, 32'h0000_0000, load data returned on timeout-aborted reads

Ports:
clk  in  1  core clock
rst_sync  in  1  synchronous active-high reset
access_ram_read  in  1  core load request (level, held while stalled)
access_ram_write  in  1  core store request (level, held while stalled)
access_ram_write_width  in  2  store width: 00 byte, 01 half, 10 word, 11 reserved
access_ram_raddr  in  32  load byte address
access_ram_waddr  in  32  store byte address
access_ram_wdata  in  32  store data, right-aligned
access_ram_rdata  out  32  load data word to core, valid in DONE
mem_stall  out  1  stall request to CoreCtrl (stall_n = ~mem_stall there)
mem_req  out  1  bus request
mem_we  out  1  1 = write
mem_addr  out  32  word address (byte addr with [1:0] = 0)
mem_be  out  4  byte enables (all 1 for reads)
mem_wdata  out  32  lane-replicated write data
mem_ready  in  1  bus completion strobe; rdata valid same cycle for reads
mem_rdata  in  32  bus read data
err_clr  in  1  clears sticky error flags
err_misalign  out  1  sticky: misaligned or reserved-width store dropped
err_timeout  out  1  sticky: access aborted by watchdog

Behaviour:
- States: IDLE, WAIT, DONE. Reset -> IDLE; all outputs 0; access_ram_rdata 0; counters 0.
- mem_stall (combinational) = (IDLE & (read|write)) | WAIT. It is low in DONE.
- IDLE with a request:
  - Latch we, addr, be and wdata into registers. Go to WAIT.
  - If both read and write are asserted, the write wins and the read is dropped; no flag is raised.
- IDLE with a store that is misaligned (half with addr[0]=1, word with addr[1:0]≠0) or has width 11:
  - No bus access. Set err_misalign. Go directly to DONE (1 stall cycle).
- Loads are never misaligned: mem_addr = raddr & ~3. The core performs byte/half extraction and extension.
- Byte lanes:
  - byte: be = 1<<addr[1:0], wdata = {4{wdata[7:0]}}.
  - half: be = addr[1] ? 1100 : 0011, wdata = {2{wdata[15:0]}}.
  - word: be = 1111.
- WAIT:
  - mem_req=1; mem_we/addr/be/wdata are driven from the latched registers and held stable until mem_ready.
  - On mem_ready: register mem_rdata into access_ram_rdata (reads only) and go to DONE.
  - Watchdog: 16-bit counter cleared on entry to WAIT, incremented each WAIT cycle without mem_ready. When count == TIMEOUT_CYCLES-1 and mem_ready=0: drop mem_req next cycle, set err_timeout, load access_ram_rdata = ERR_RDATA for reads, go to DONE.
  - mem_ready in the same cycle as expiry counts as success.
- DONE:
  - One cycle; mem_req=0; access_ram_rdata holds the result. The pipeline advances at the end of this cycle.
  - Requests seen in DONE belong to the already-served instruction and are ignored. Go to IDLE.
- Back-to-back accesses: the next request is seen in IDLE the cycle after DONE.
- Minimum occupancy is 3 cycles (IDLE, WAIT, DONE) with 2 stall cycles when mem_ready is asserted in the first WAIT cycle.
- mem_ready outside WAIT is ignored.
- access_ram_rdata holds its last value outside DONE.
- err flags: set has priority over err_clr in the same cycle; cleared only by err_clr or reset.
- rst_sync mid-access: next edge returns to IDLE and mem_req drops. The abandoned bus transaction is not completed or flagged.

Test Plan:
- Load raddr=0x104, mem_ready in first WAIT cycle with mem_rdata=0xCAFEBABE -> mem_addr=0x104, be=1111, mem_stall high exactly 2 cycles, access_ram_rdata=0xCAFEBABE in DONE.
- Byte store waddr=0x203, wdata=0x000000A5, mem_ready after 3 wait cycles -> be=1000, mem_wdata=0xA5A5A5A5, mem_addr=0x200, request fields stable across all WAIT cycles, stall 5 cycles.
- Half store waddr=0x201 -> no mem_req, err_misalign=1, stall 1 cycle. Then err_clr=1 -> flag 0. Width 11 store -> same behaviour.
- TIMEOUT_CYCLES=4, load with mem_ready never asserted -> mem_req high 4 cycles, err_timeout=1, access_ram_rdata=ERR_RDATA, FSM back to IDLE. Repeat with mem_ready on the 4th cycle -> success, no flag.
- Back-to-back load then store with zero-wait bus -> two independent transactions, IDLE between them. The request held during DONE does not cause a duplicate bus access.
- rst_sync asserted during WAIT -> next cycle state IDLE, mem_req=0, mem_stall=0 with no request, flags 0.

Source files
------------

// File: rtl/ram_access_ctrl.sv
// ram_access_ctrl
//   Sits between the core's single-cycle RAM port and a wait-stated data
//   SRAM/bus. Converts load/store requests into a req/ready handshake, stalls
//   the core until each access completes, generates byte enables and
//   lane-replicated store data, rejects misaligned stores and aborts accesses
//   that the bus never completes.
//
// Ports
//   clk, rst_sync             core clock, synchronous active-high reset
//   access_ram_*              core request side (read/write levels, width,
//                             byte addresses, right-aligned store data) and
//                             load data back to the core
//   mem_stall                 stall request to CoreCtrl
//   mem_req/we/addr/be/wdata  bus request fields (word address)
//   mem_ready/mem_rdata       bus completion strobe and read data
//   err_clr                   clears the sticky error flags
//   err_misalign/err_timeout  sticky error flags
module ram_access_ctrl #(
    parameter int unsigned TIMEOUT_CYCLES = 255,
    parameter logic [31:0] ERR_RDATA      = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst_sync,
    input  logic        access_ram_read,
    input  logic        access_ram_write,
    input  logic [1:0]  access_ram_write_width,
    input  logic [31:0] access_ram_raddr,
    input  logic [31:0] access_ram_waddr,
    input  logic [31:0] access_ram_wdata,
    output logic [31:0] access_ram_rdata,
    output logic        mem_stall,
    output logic        mem_req,
    output logic        mem_we,
    output logic [31:0] mem_addr,
    output logic [3:0]  mem_be,
    output logic [31:0] mem_wdata,
    input  logic        mem_ready,
    input  logic [31:0] mem_rdata,
    input  logic        err_clr,
    output logic        err_misalign,
    output logic        err_timeout
);

    typedef enum logic [1:0] {IDLE, WAIT, DONE} state_t;

    localparam logic [15:0] WD_LAST = 16'(TIMEOUT_CYCLES - 1);

    state_t      state;
    logic [15:0] wd_cnt;

    // Store decode: byte enables, replicated lanes, alignment check.
    logic [1:0]  wlow;
    logic        st_bad;
    logic [3:0]  st_be;
    logic [31:0] st_wdata;

    assign wlow = access_ram_waddr[1:0];

    always_comb begin
        st_bad   = 1'b0;
        st_be    = 4'b1111;
        st_wdata = access_ram_wdata;
        case (access_ram_write_width)
            2'b00: begin
                st_be    = 4'b0001 << wlow;
                st_wdata = {4{access_ram_wdata[7:0]}};
            end
            2'b01: begin
                st_be    = wlow[1] ? 4'b1100 : 4'b0011;
                st_wdata = {2{access_ram_wdata[15:0]}};
                st_bad   = wlow[0];
            end
            2'b10:   st_bad = |wlow;
            default: st_bad = 1'b1;
        endcase
    end

    // In DONE the request still held by the core belongs to the instruction
    // just served, so it must not stall again.
    assign mem_stall = ((state == IDLE) && (access_ram_read || access_ram_write))
                     || (state == WAIT);

    always_ff @(posedge clk) begin
        if (rst_sync) begin
            state            <= IDLE;
            wd_cnt           <= '0;
            mem_req          <= 1'b0;
            mem_we           <= 1'b0;
            mem_addr         <= '0;
            mem_be           <= '0;
            mem_wdata        <= '0;
            access_ram_rdata <= '0;
            err_misalign     <= 1'b0;
            err_timeout      <= 1'b0;
        end else begin
            // Clear first; a set later in this block takes priority.
            if (err_clr) begin
                err_misalign <= 1'b0;
                err_timeout  <= 1'b0;
            end

            case (state)
                IDLE: begin
                    // Write wins when both are requested; the read is dropped.
                    if (access_ram_write) begin
                        if (st_bad) begin
                            err_misalign <= 1'b1;
                            state        <= DONE;
                        end else begin
                            mem_req   <= 1'b1;
                            mem_we    <= 1'b1;
                            mem_addr  <= {access_ram_waddr[31:2], 2'b00};
                            mem_be    <= st_be;
                            mem_wdata <= st_wdata;
                            wd_cnt    <= '0;
                            state     <= WAIT;
                        end
                    end else if (access_ram_read) begin
                        mem_req   <= 1'b1;
                        mem_we    <= 1'b0;
                        mem_addr  <= {access_ram_raddr[31:2], 2'b00};
                        mem_be    <= 4'b1111;
                        mem_wdata <= '0;
                        wd_cnt    <= '0;
                        state     <= WAIT;
                    end
                end
                WAIT: begin
                    // Ready in the expiry cycle still counts as success.
                    if (mem_ready) begin
                        mem_req <= 1'b0;
                        if (!mem_we) access_ram_rdata <= mem_rdata;
                        state <= DONE;
                    end else if (wd_cnt == WD_LAST) begin
                        mem_req     <= 1'b0;
                        err_timeout <= 1'b1;
                        if (!mem_we) access_ram_rdata <= ERR_RDATA;
                        state <= DONE;
                    end else begin
                        wd_cnt <= wd_cnt + 16'd1;
                    end
                end
                DONE:    state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_ram_access_ctrl.sv
module tb_ram_access_ctrl;

    localparam int          T   = 4;
    localparam logic [31:0] ERR = 32'hDEAD_BEEF;

    logic        clk = 1'b0;
    logic        rst_sync = 1'b1;
    logic        access_ram_read = 1'b0, access_ram_write = 1'b0;
    logic [1:0]  access_ram_write_width = 2'b00;
    logic [31:0] access_ram_raddr = '0, access_ram_waddr = '0, access_ram_wdata = '0;
    logic [31:0] access_ram_rdata;
    logic        mem_stall, mem_req, mem_we;
    logic [31:0] mem_addr, mem_wdata;
    logic [3:0]  mem_be;
    logic        mem_ready = 1'b0;
    logic [31:0] mem_rdata = '0;
    logic        err_clr = 1'b0;
    logic        err_misalign, err_timeout;

    int checks = 0, failures = 0;

    // Reference state
    logic [31:0] m_rdata = '0;
    bit          m_mis = 0, m_to = 0;

    ram_access_ctrl #(.TIMEOUT_CYCLES(T), .ERR_RDATA(ERR)) dut (
        .clk(clk), .rst_sync(rst_sync),
        .access_ram_read(access_ram_read), .access_ram_write(access_ram_write),
        .access_ram_write_width(access_ram_write_width),
        .access_ram_raddr(access_ram_raddr), .access_ram_waddr(access_ram_waddr),
        .access_ram_wdata(access_ram_wdata), .access_ram_rdata(access_ram_rdata),
        .mem_stall(mem_stall), .mem_req(mem_req), .mem_we(mem_we),
        .mem_addr(mem_addr), .mem_be(mem_be), .mem_wdata(mem_wdata),
        .mem_ready(mem_ready), .mem_rdata(mem_rdata),
        .err_clr(err_clr), .err_misalign(err_misalign), .err_timeout(err_timeout)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // One core access. wait_n = WAIT cycles without ready before ready is
    // given; wait_n >= T means the bus never answers. Called at a negedge
    // with the DUT idle; returns at the negedge after DONE.
    task automatic do_access(input bit rd, input bit wr, input logic [1:0] w,
                             input logic [31:0] ra, input logic [31:0] wa,
                             input logic [31:0] wd, input int wait_n,
                             input logic [31:0] rval, input bit clr);
        bit          is_rd, bad, tmo, done;
        int          exp_req, stall_n, req_n;
        logic [3:0]  ebe;
        logic [31:0] ewd, eaddr;

        is_rd = rd && !wr;
        bad   = wr && (w == 2'd3 || (w == 2'd1 && wa % 2 != 0) || (w == 2'd2 && wa % 4 != 0));
        eaddr = wr ? wa - wa % 4 : ra - ra % 4;
        case (w)
            2'd0:    begin ebe = 4'(1 << (wa % 4));            ewd = {24'b0, wd[7:0]} * 32'h0101_0101; end
            2'd1:    begin ebe = (wa % 4 >= 2) ? 4'hC : 4'h3;  ewd = {16'b0, wd[15:0]} * 32'h0001_0001; end
            default: begin ebe = 4'hF;                         ewd = wd; end
        endcase
        if (is_rd) ebe = 4'hF;
        tmo     = !bad && wait_n >= T;
        exp_req = bad ? 0 : (tmo ? T : wait_n + 1);

        access_ram_read = rd; access_ram_write = wr; access_ram_write_width = w;
        access_ram_raddr = ra; access_ram_waddr = wa; access_ram_wdata = wd;
        err_clr = clr;
        stall_n = 0; req_n = 0; done = 0;
        for (int c = 0; c < 40 && !done; c++) begin
            #1;
            if (c == 0) chk("idle_req", mem_req, 0);
            if (!mem_stall) done = 1;
            else begin
                stall_n++;
                if (mem_req) begin
                    req_n++;
                    chk("bus_addr", mem_addr, eaddr);
                    chk("bus_we", mem_we, wr);
                    chk("bus_be", mem_be, ebe);
                    if (wr) chk("bus_wdata", mem_wdata, ewd);
                    mem_ready = (req_n == wait_n + 1);
                    mem_rdata = mem_ready ? rval : $urandom;
                end else begin
                    mem_ready = 1'($urandom_range(0, 1));
                    mem_rdata = $urandom;
                end
                @(negedge clk);
            end
        end
        if (!done) chk("done_bound", 0, 1);

        if (clr) begin m_mis = 0; m_to = 0; end
        if (bad) m_mis = 1;
        if (tmo) m_to = 1;
        if (is_rd) m_rdata = tmo ? ERR : rval;

        chk("stall_cycles", stall_n, exp_req + 1);
        chk("req_cycles", req_n, exp_req);
        chk("done_req", mem_req, 0);
        chk("done_rdata", access_ram_rdata, m_rdata);
        chk("done_misalign", err_misalign, m_mis);
        chk("done_timeout", err_timeout, m_to);
        err_clr   = 1'b0;
        mem_ready = 1'($urandom_range(0, 1));
        @(negedge clk);
        mem_ready = 1'b0;
    endtask

    // Idle cycles with no request; err_clr optionally asserted.
    task automatic gap(input int n, input bit clr);
        access_ram_read = 1'b0; access_ram_write = 1'b0;
        for (int i = 0; i < n; i++) begin
            err_clr   = clr;
            mem_ready = 1'($urandom_range(0, 1));
            #1;
            chk("gap_stall", mem_stall, 0);
            chk("gap_req", mem_req, 0);
            chk("gap_rdata", access_ram_rdata, m_rdata);
            chk("gap_misalign", err_misalign, m_mis);
            chk("gap_timeout", err_timeout, m_to);
            if (clr) begin m_mis = 0; m_to = 0; end
            @(negedge clk);
        end
        err_clr = 1'b0; mem_ready = 1'b0;
    endtask

    initial begin
        repeat (3) @(negedge clk);
        rst_sync = 1'b0;
        #1;
        chk("rst_stall", mem_stall, 0);
        chk("rst_req", mem_req, 0);
        chk("rst_fields", {mem_we, mem_be, mem_addr}, 0);
        chk("rst_wdata", mem_wdata, 0);
        chk("rst_rdata", access_ram_rdata, 0);
        chk("rst_flags", {err_misalign, err_timeout}, 0);
        @(negedge clk);

        // Directed cases
        do_access(1, 0, 2'd0, 32'h104, 0, 0, 0, 32'hCAFE_BABE, 0);
        gap(1, 0);
        do_access(0, 1, 2'd0, 0, 32'h203, 32'h0000_00A5, 3, 0, 0);
        gap(1, 0);
        do_access(0, 1, 2'd1, 0, 32'h201, 32'h1234_5678, 0, 0, 0);
        gap(2, 1);
        do_access(0, 1, 2'd3, 0, 32'h200, 32'h1234_5678, 0, 0, 0);
        gap(1, 1);
        do_access(1, 0, 2'd0, 32'h40, 0, 0, 9, 32'h1111_2222, 0);
        gap(1, 1);
        do_access(1, 0, 2'd0, 32'h44, 0, 0, T - 1, 32'h3333_4444, 0);
        gap(1, 0);
        // Back-to-back, zero-wait
        do_access(1, 0, 2'd0, 32'h80, 0, 0, 0, 32'h5555_6666, 0);
        do_access(0, 1, 2'd2, 0, 32'h84, 32'h7777_8888, 0, 0, 0);
        // Both requested: write wins
        do_access(1, 1, 2'd1, 32'h90, 32'h92, 32'h0000_BEEF, 1, 32'h9999_AAAA, 0);
        // Set beats clear in the same cycle
        do_access(0, 1, 2'd2, 0, 32'h301, 32'h1, 0, 0, 1);
        gap(1, 0);

        // Randomised traffic
        for (int i = 0; i < 150; i++) begin
            int          kind;
            logic [1:0]  w;
            logic [31:0] ra, wa, wd, rv;
            kind = $urandom_range(0, 2);
            w  = 2'($urandom_range(0, 3));
            ra = $urandom; wa = $urandom; wd = $urandom; rv = $urandom;
            do_access(kind != 1, kind != 0, w, ra, wa, wd, $urandom_range(0, 5), rv,
                      ($urandom_range(0, 7) == 0));
            if ($urandom_range(0, 1) == 1)
                gap($urandom_range(1, 2), ($urandom_range(0, 3) == 0));
        end

        // Reset in the middle of a WAIT
        do_access(0, 1, 2'd3, 0, 32'h0, 32'h0, 0, 0, 0);
        access_ram_read = 1'b1; access_ram_write = 1'b0; access_ram_raddr = 32'h500;
        repeat (3) @(negedge clk);
        #1;
        chk("pre_rst_req", mem_req, 1);
        rst_sync = 1'b1; access_ram_read = 1'b0; mem_ready = 1'b0;
        @(negedge clk);
        rst_sync = 1'b0;
        m_rdata = '0; m_mis = 0; m_to = 0;
        #1;
        chk("midrst_req", mem_req, 0);
        chk("midrst_stall", mem_stall, 0);
        chk("midrst_flags", {err_misalign, err_timeout}, 0);
        chk("midrst_rdata", access_ram_rdata, 0);
        @(negedge clk);
        do_access(1, 0, 2'd0, 32'h508, 0, 0, 1, 32'hABCD_0123, 0);
        gap(1, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
